// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter service controller: FSM state encoding,
// default widths and grant-vector helper functions.
package arb_pkg;

  localparam int N_DEF  = 4;
  localparam int LW_DEF = 4;
  localparam int CW_DEF = 8;

  // Widest grant vector the helpers accept; callers zero-extend into it.
  localparam int MAX_N  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Isolate the lowest set bit (two's-complement trick); zero stays zero.
  function automatic logic [MAX_N-1:0] lowest_onehot(input logic [MAX_N-1:0] v);
    return v & (~v + MAX_N'(1));
  endfunction

  // True when exactly one bit is set.
  function automatic bit is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] q
);

  // Count register: clear beats increment, saturate at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated.
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CW'(1);
    end
  end

endmodule

// File: rtl/arb_service_ctrl.sv
// Downstream consumer of the 4-way random-priority arbiter. Acknowledges a
// request, samples the one-hot grant, holds the shared resource for a
// programmable number of cycles, then pulses done and returns to idle.
// Keeps a saturating grant count per requester and a sticky conflict flag
// for multi-hot grants.
module arb_service_ctrl
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic [N-1:0]    grant_vec,
  input  logic [LW-1:0]   svc_len,
  input  logic            cnt_clr,
  output logic            ack,
  output logic            busy,
  output logic [N-1:0]    owner,
  output logic            done,
  output logic [N-1:0]    done_vec,
  output logic            conflict,
  output logic [N*CW-1:0] grant_cnt
);

  state_e        state_q, state_d;
  logic [LW-1:0] svc_q, svc_d;
  logic [N-1:0]  pick;
  logic [N-1:0]  owner_d;
  logic [N-1:0]  done_vec_d;
  logic [N-1:0]  inc_vec;
  logic          conflict_d;
  logic          ack_d;
  logic          busy_d;
  logic          done_d;

  // FSM state and remaining-service counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      svc_q   <= '0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
    end
  end

  // Next-state, service counter load/decrement and next output values.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    svc_d      = svc_q;
    owner_d    = owner;
    conflict_d = conflict;
    inc_vec    = '0;
    // Multi-hot grants resolve to the lowest-index requester.
    pick       = N'(lowest_onehot(MAX_N'(grant_vec)));

    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (grant_vec == '0) begin
          // Request withdrawn before the grant landed: nothing to serve.
          state_d = ST_IDLE;
        end else begin
          owner_d = pick;
          svc_d   = (svc_len == '0) ? LW'(1) : svc_len;
          inc_vec = pick;
          if (!is_onehot(MAX_N'(grant_vec))) conflict_d = 1'b1;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (svc_q <= LW'(1)) begin
          svc_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          svc_d   = svc_q - LW'(1);
        end
      end
      ST_RELEASE: begin
        owner_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    ack_d      = (state_d == ST_GRANT);
    busy_d     = (state_d == ST_SERVE) || (state_d == ST_RELEASE);
    done_d     = (state_d == ST_RELEASE);
    done_vec_d = done_d ? owner_d : '0;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack      <= 1'b0;
      busy     <= 1'b0;
      owner    <= '0;
      done     <= 1'b0;
      done_vec <= '0;
      conflict <= 1'b0;
    end else begin
      ack      <= ack_d;
      busy     <= busy_d;
      owner    <= owner_d;
      done     <= done_d;
      done_vec <= done_vec_d;
      conflict <= conflict_d;
    end
  end

  // One saturating grant counter per requester.
  for (genvar i = 0; i < N; i++) begin : g_cnt
    sat_counter #(
      .CW (CW)
    ) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (inc_vec[i]),
      .clr  (cnt_clr),
      .q    (grant_cnt[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_arb_service_ctrl.sv
// Scoreboard bench for arb_service_ctrl. The driver plays the arbiter:
// it raises req, answers ack with a grant vector and service length, and
// pushes the expected completion (owner, done cycle, busy length) into a
// queue. A separate monitor pops an entry on every done pulse.
module tb_arb_service_ctrl;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req;
  logic [N-1:0]    grant_vec;
  logic [LW-1:0]   svc_len;
  logic            cnt_clr;
  logic            ack;
  logic            busy;
  logic [N-1:0]    owner;
  logic            done;
  logic [N-1:0]    done_vec;
  logic            conflict;
  logic [N*CW-1:0] grant_cnt;

  arb_service_ctrl #(.N(N), .LW(LW), .CW(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .grant_vec (grant_vec),
    .svc_len   (svc_len),
    .cnt_clr   (cnt_clr),
    .ack       (ack),
    .busy      (busy),
    .owner     (owner),
    .done      (done),
    .done_vec  (done_vec),
    .conflict  (conflict),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] owner;
    int unsigned  done_cyc;
    int unsigned  len;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  int  m_cnt[N];
  bit  m_conflict;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_conflict = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_cnt%0d", tag, i), 32'(grant_cnt[i*CW +: CW]), 32'(m_cnt[i]));
    check({tag, "_conflict"}, 32'(conflict), 32'(m_conflict));
  endtask

  // Monitor: pops one expectation per done pulse.
  int run = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      run = 0;
    end else begin
      if (busy) run++; else run = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_vec", 32'(done_vec), 32'(e.owner));
          check("done_owner", 32'(owner), 32'(e.owner));
          check("done_cycle", cyc, e.done_cyc);
          check("busy_len", 32'(run), e.len + 1);
        end
      end
    end
  end

  // One arbitration round. Called just after a negedge with the DUT idle.
  // abort=1 pulses rstn during the second SERVE cycle.
  task automatic do_txn(input logic [N-1:0] gv, input logic [LW-1:0] len,
                        input bit clr, input bit abort);
    bit          got;
    bit          fin;
    int          own_idx;
    int          ones;
    int unsigned l;
    exp_t        e;
    req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      req = 1'b0;
      return;
    end
    // GRANT cycle: answer the ack.
    grant_vec = gv;
    svc_len   = len;
    cnt_clr   = clr;
    req       = (gv == '0) ? 1'b0 : 1'($urandom_range(0, 1));
    own_idx = -1;
    ones    = 0;
    for (int i = 0; i < N; i++) begin
      if (gv[i]) begin
        ones++;
        if (own_idx < 0) own_idx = i;
      end
    end
    l = (len == 0) ? 1 : int'(len);
    if (own_idx >= 0) begin
      e.owner    = N'(1) << own_idx;
      e.done_cyc = cyc + l + 1;
      e.len      = l;
      exp_q.push_back(e);
      if (ones > 1) m_conflict = 1'b1;
    end
    if (clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (own_idx >= 0 && m_cnt[own_idx] < CMAX) begin
      m_cnt[own_idx]++;
    end

    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("busy_after_grant", 32'(busy), 32'(own_idx >= 0));
    if (own_idx >= 0) check("owner_latched", 32'(owner), 32'(e.owner));
    // Inputs are ignored while serving; scramble them.
    cnt_clr   = 1'b0;
    svc_len   = LW'($urandom);
    grant_vec = N'($urandom);
    req       = 1'b0;

    if (abort) begin
      @(negedge clk);
      rstn = 1'b0;
      if (own_idx >= 0) void'(exp_q.pop_back());
      model_reset();
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_done_vec", 32'(done_vec), 32'd0);
      check_counts("rst_mid");
      @(negedge clk);
      rstn = 1'b1;
      grant_vec = '0;
      repeat (3) @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
      return;
    end

    fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("release_timeout", 32'(fin), 32'd1);
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    grant_vec = '0;
    check_counts("post");
  endtask

  task automatic idle_clear();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    check_counts("idle_clr");
  endtask

  function automatic logic [N-1:0] rand_gv();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r <= 6) return N'(1) << $urandom_range(0, N-1);
    return N'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    req       = 1'b1;
    grant_vec = '0;
    svc_len   = '0;
    cnt_clr   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_counts("reset");
    rstn = 1'b1;
    req  = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_txn(4'b0100, 4'd3, 1'b0, 1'b0);
    do_txn(4'b0001, 4'd0, 1'b0, 1'b0);
    do_txn(4'b0000, 4'd7, 1'b0, 1'b0);
    do_txn(4'b1010, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_txn(4'b0001, 4'd1, 1'b0, 1'b0);
    do_txn(4'b0001, 4'd2, 1'b1, 1'b0);
    do_txn(4'b1000, 4'd5, 1'b0, 1'b1);
    do_txn(4'b0010, 4'd4, 1'b0, 1'b0);

    // Randomized rounds.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 11) == 0) idle_clear();
      do_txn(rand_gv(), LW'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(negedge clk);
    check("pending_done", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
